// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the default bus widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side handshake bundle for the memory port arbiter.
// slave = arbiter view, master = the surrounding requesters and memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ready;
  logic              o_if_valid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic              i_d_wen;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_mask;
  logic              o_d_ready;
  logic              o_d_valid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_mem_req;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_mask;
  logic              i_mem_ready;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ready, o_if_valid, o_if_rdata,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_ready, o_d_valid, o_d_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ready, o_if_valid, o_if_rdata,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_ready, o_d_valid, o_d_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting; force_if once it saturates.
// Zero latency on o_force_if (registered count), no backpressure.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d_grant,
  input  logic i_if_grant,
  input  logic i_if_pending,
  output logic o_force_if
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_if_grant) begin
      cnt_d = '0;
    end else if (i_d_grant) begin
      if (!i_if_pending) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_force_if = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store, data-priority.
// Grant->mem_req 1 cycle, grant->response >= 3 cycles; requesters hold requests while busy.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  state_e            st_q, st_d;
  owner_e            owner_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_valid_q, d_valid_q;
  logic              abandon_q;

  logic idle, grant_d, grant_if, force_if;

  // Data wins a contested slot unless fetch has been passed over STARVE_MAX times.
  assign idle     = (st_q == ST_IDLE);
  assign grant_d  = idle && bus.i_d_req && !(bus.i_if_req && force_if);
  assign grant_if = idle && bus.i_if_req && !grant_d;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_d_grant   (grant_d),
    .i_if_grant  (grant_if),
    .i_if_pending(bus.i_if_req),
    .o_force_if  (force_if)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (grant_d || grant_if) st_d = ST_ISSUE;
      ST_ISSUE: if (bus.i_mem_ready)     st_d = ST_WAIT;
      ST_WAIT:  if (bus.i_mem_valid)     st_d = ST_IDLE;
      default:                           st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q    <= OWN_IF;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      abandon_q  <= 1'b1;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (grant_if) begin
        owner_q <= OWN_IF;
        wen_q   <= 1'b0;
        addr_q  <= bus.i_if_addr;
        wdata_q <= '0;
        mask_q  <= '1;
      end else if (grant_d) begin
        owner_q <= OWN_D;
        wen_q   <= bus.i_d_wen;
        addr_q  <= bus.i_d_addr;
        wdata_q <= bus.i_d_wdata;
        mask_q  <= bus.i_d_mask;
      end
      // A response left over from a transaction killed by reset is tolerated until the next accept.
      if (st_q == ST_ISSUE && bus.i_mem_ready) begin
        abandon_q <= 1'b0;
      end
      if (st_q == ST_WAIT && bus.i_mem_valid) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= bus.i_mem_rdata;
          if_valid_q <= 1'b1;
        end else begin
          if (!wen_q) d_rdata_q <= bus.i_mem_rdata;
          d_valid_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_if_ready  = grant_if;
    bus.o_d_ready   = grant_d;
    bus.o_if_valid  = if_valid_q;
    bus.o_if_rdata  = if_rdata_q;
    bus.o_d_valid   = d_valid_q;
    bus.o_d_rdata   = d_rdata_q;
    bus.o_mem_req   = (st_q == ST_ISSUE);
    bus.o_mem_wen   = (st_q == ST_ISSUE) && wen_q;
    bus.o_mem_addr  = addr_q;
    bus.o_mem_wdata = wdata_q;
    bus.o_mem_mask  = mask_q;
  end

  mem_rsp_in_window: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.i_mem_valid && st_q != ST_WAIT && !abandon_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch-only, contention, starvation, stall, store, reset-abort.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in an ISSUE cycle: accept now, respond the next cycle; returns in the valid-pulse cycle.
  task automatic serve(input logic [31:0] rdata);
    bus.i_mem_ready = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = rdata;
    cyc();
    bus.i_mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          ngr;
    int          nd;
    int          budget;
    logic        took_if;
    logic [6:0]  order;
    logic [2:0]  exp_cnt [7];

    rst             = 1'b1;
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = '0;
    bus.i_d_req     = 1'b0;
    bus.i_d_wen     = 1'b0;
    bus.i_d_addr    = '0;
    bus.i_d_wdata   = '0;
    bus.i_d_mask    = '0;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    repeat (2) cyc();
    #1;
    chk("rst_ctrl", {bus.o_if_ready, bus.o_d_ready, bus.o_if_valid, bus.o_d_valid,
                     bus.o_mem_req, bus.o_mem_wen}, 6'b0);
    chk("rst_fields", {bus.o_mem_addr, bus.o_mem_wdata}, 64'h0);
    chk("rst_mask", bus.o_mem_mask, 4'h0);
    chk("rst_rdata", {bus.o_if_rdata, bus.o_d_rdata}, 64'h0);
    chk("rst_state", dut.st_q, ST_IDLE);
    chk("rst_owner", dut.owner_q, OWN_IF);
    chk("rst_starve", dut.u_starve.cnt_q, 3'd0);
    rst = 1'b0;
    cyc();

    // Fetch only; memory responds two cycles after accepting.
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h100;
    #1;
    chk("if_only_ready", {bus.o_if_ready, bus.o_d_ready}, 2'b10);
    cyc();
    bus.i_if_req = 1'b0;
    #1;
    chk("if_only_issue", {bus.o_mem_req, bus.o_mem_wen, bus.o_if_ready}, 3'b100);
    chk("if_only_addr", bus.o_mem_addr, 32'h100);
    chk("if_only_mask", {bus.o_mem_mask, bus.o_mem_wdata}, {4'hF, 32'h0});
    bus.i_mem_ready = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
    #1;
    chk("if_only_req_drop", bus.o_mem_req, 1'b0);
    cyc();
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hDEADBEEF;
    cyc();
    bus.i_mem_valid = 1'b0;
    #1;
    chk("if_only_valid", {bus.o_if_valid, bus.o_d_valid}, 2'b10);
    chk("if_only_rdata", bus.o_if_rdata, 32'hDEADBEEF);
    chk("if_only_d_quiet", bus.o_d_rdata, 32'h0);
    cyc();
    chk("if_only_pulse_end", bus.o_if_valid, 1'b0);
    chk("if_only_hold", bus.o_if_rdata, 32'hDEADBEEF);

    // Simultaneous fetch and load: data first, fetch granted in the load's valid cycle.
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h200;
    bus.i_d_req   = 1'b1;
    bus.i_d_wen   = 1'b0;
    bus.i_d_addr  = 32'h400;
    bus.i_d_mask  = 4'hF;
    #1;
    chk("both_grant", {bus.o_if_ready, bus.o_d_ready}, 2'b01);
    cyc();
    bus.i_d_req = 1'b0;
    #1;
    chk("both_d_issue", {bus.o_mem_req, bus.o_mem_wen, bus.o_if_ready}, 3'b100);
    chk("both_d_addr", bus.o_mem_addr, 32'h400);
    chk("both_starve1", dut.u_starve.cnt_q, 3'd1);
    serve(32'hA5A50001);
    #1;
    chk("both_d_valid", {bus.o_d_valid, bus.o_if_ready}, 2'b11);
    chk("both_d_rdata", bus.o_d_rdata, 32'hA5A50001);
    cyc();
    bus.i_if_req = 1'b0;
    #1;
    chk("both_if_addr", bus.o_mem_addr, 32'h200);
    chk("both_starve0", dut.u_starve.cnt_q, 3'd0);
    serve(32'h0BADF00D);
    #1;
    chk("both_if_valid", {bus.o_if_valid, bus.o_if_rdata}, {1'b1, 32'h0BADF00D});

    // Fetch held against six back-to-back stores.
    exp_cnt      = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
    order        = '0;
    ngr          = 0;
    nd           = 0;
    budget       = 0;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h300;
    bus.i_d_req  = 1'b1;
    bus.i_d_wen  = 1'b1;
    bus.i_d_addr = 32'h20;
    bus.i_d_wdata = 32'h11110000;
    bus.i_d_mask = 4'hF;
    while (ngr < 7 && budget < 60) begin
      #1;
      budget++;
      if (bus.o_if_ready || bus.o_d_ready) begin
        took_if    = bus.o_if_ready;
        order[ngr] = took_if;
        cyc();
        if (took_if) begin
          bus.i_if_req = 1'b0;
        end else begin
          nd++;
          if (nd == 6) bus.i_d_req = 1'b0;
        end
        chk($sformatf("starve_cnt%0d", ngr), dut.u_starve.cnt_q, exp_cnt[ngr]);
        ngr++;
        serve(32'h0);
      end else begin
        cyc();
      end
    end
    chk("starve_grants", ngr, 7);
    chk("starve_order", order, 7'b0010000);

    // Memory stalls acceptance for five cycles while fetch waits.
    bus.i_d_req  = 1'b1;
    bus.i_d_wen  = 1'b0;
    bus.i_d_addr = 32'h44;
    #1;
    chk("stall_grant", bus.o_d_ready, 1'b1);
    cyc();
    bus.i_d_req   = 1'b0;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h500;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_hold%0d", i),
          {bus.o_mem_req, bus.o_mem_wen, bus.o_mem_addr, bus.o_if_ready, bus.o_d_ready},
          {1'b1, 1'b0, 32'h44, 2'b00});
      cyc();
    end
    bus.i_if_req = 1'b0;
    serve(32'h44440044);
    #1;
    chk("stall_valid", {bus.o_d_valid, bus.o_d_rdata}, {1'b1, 32'h44440044});

    // Partial-mask store; the ack leaves load data untouched.
    bus.i_d_req   = 1'b1;
    bus.i_d_wen   = 1'b1;
    bus.i_d_addr  = 32'h10;
    bus.i_d_wdata = 32'h12345678;
    bus.i_d_mask  = 4'b0011;
    #1;
    chk("st_grant", bus.o_d_ready, 1'b1);
    cyc();
    bus.i_d_req = 1'b0;
    #1;
    chk("st_bus_ctrl", {bus.o_mem_req, bus.o_mem_wen, bus.o_mem_mask}, {2'b11, 4'b0011});
    chk("st_bus_data", {bus.o_mem_addr, bus.o_mem_wdata}, {32'h10, 32'h12345678});
    serve(32'hFFFF0000);
    #1;
    chk("st_ack", {bus.o_d_valid, bus.o_if_valid}, 2'b10);
    chk("st_rdata_kept", bus.o_d_rdata, 32'h44440044);

    // Reset while waiting for a load response; the late response is dropped.
    bus.i_d_req  = 1'b1;
    bus.i_d_wen  = 1'b0;
    bus.i_d_addr = 32'h80;
    cyc();
    bus.i_d_req     = 1'b0;
    bus.i_mem_ready = 1'b1;
    cyc();
    bus.i_mem_ready = 1'b0;
    #1;
    chk("rstmid_in_wait", dut.st_q, ST_WAIT);
    rst = 1'b1;
    #1;
    chk("rstmid_state", dut.st_q, ST_IDLE);
    chk("rstmid_outs", {bus.o_mem_req, bus.o_mem_addr, bus.o_d_rdata}, 65'h0);
    cyc();
    rst = 1'b0;
    cyc();
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h77;
    cyc();
    bus.i_mem_valid = 1'b0;
    #1;
    chk("rstmid_no_valid", {bus.o_if_valid, bus.o_d_valid}, 2'b00);
    chk("rstmid_idle", dut.st_q, ST_IDLE);
    chk("rstmid_rdata", bus.o_d_rdata, 32'h0);
    cyc();
    chk("rstmid_still_quiet", {bus.o_if_valid, bus.o_d_valid, bus.o_mem_req}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-ported unified memory between instruction fetch (IF) and data load/store (D) requesters.
- Sits between fetch/LSU stages and the memory model; the decoded o_mem_wen / load information from the control decoder drives the D side.
- Single outstanding transaction, ready/valid handshakes, data-priority arbitration with bounded fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (mask width DATA_W/8)
- STARVE_MAX, 4, max consecutive D grants while IF pending before IF forced

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_if_req  in  1  fetch request, held until o_if_ready
- i_if_addr  in  ADDR_W  fetch address, stable while i_if_req
- o_if_ready  out  1  one-cycle grant/accept pulse for IF
- o_if_valid  out  1  one-cycle fetch response pulse
- o_if_rdata  out  DATA_W  fetch data, valid with o_if_valid
- i_d_req  in  1  data request, held until o_d_ready
- i_d_wen  in  1  1=store, 0=load
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- i_d_mask  in  DATA_W/8  byte enables
- o_d_ready  out  1  one-cycle grant/accept pulse for D
- o_d_valid  out  1  one-cycle response (load data or store ack)
- o_d_rdata  out  DATA_W  load data, valid with o_d_valid
- o_mem_req  out  1  memory request
- o_mem_wen  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_mask  out  DATA_W/8  memory byte enables
- i_mem_ready  in  1  memory accepts request this cycle
- i_mem_valid  in  1  memory response (read data or write ack)
- i_mem_rdata  in  DATA_W  memory read data

Behaviour:
- One clock i_clk; i_rst asynchronous, active-high.
- Reset: state=IDLE, starve_cnt=0, owner=IF; all o_* ready/valid/req/wen = 0, o_mem_addr/wdata/mask = 0, o_if_rdata/o_d_rdata = 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: if any req, grant, latch owner and fields, pulse owner's o_*_ready for that cycle, go ISSUE. No req: stay.
- Arbitration, both req: D wins unless starve_cnt == STARVE_MAX, then IF wins. Single req: that requester wins.
- starve_cnt: +1 (saturating at STARVE_MAX) on D grant with i_if_req high; cleared on IF grant or on D grant with i_if_req low.
- ISSUE: o_mem_req=1, o_mem_* driven from latched fields (IF: wen=0, mask=all ones, wdata=0). Hold until i_mem_ready=1, then go WAIT; o_mem_req drops next cycle.
- WAIT: on i_mem_valid, copy i_mem_rdata to owner's rdata register, pulse owner's o_*_valid next cycle, go IDLE. Stores also wait for i_mem_valid (ack); o_d_rdata is then unchanged.
- Response never earlier than the cycle after acceptance. i_mem_valid in IDLE/ISSUE is ignored (assertion fires).
- Latency: grant->o_mem_req 1 cycle; minimum grant-to-response 3 cycles; next grant earliest in the cycle o_*_valid pulses.
- Requests arriving while busy are not accepted; the requester holds them.
- rdata registers hold last value between responses.
- Reset mid-transaction: outstanding transaction abandoned, no valid pulse issued, late memory response ignored.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_ISSUE, ST_WAIT), owner encoding (OWN_IF, OWN_D), default widths.
- Natural sub-module: mem_arb_starve_ctr (saturating counter with clear; outputs force_if).

Test Plan:
- IF only, addr 0x100, i_mem_ready on first ISSUE cycle, response 2 cycles later with 0xDEADBEEF -> o_if_ready at t0, o_mem_req at t1, o_if_valid with 0xDEADBEEF; o_d_* stay 0.
- Simultaneous IF 0x200 + D load 0x400 -> D granted first (o_mem_addr=0x400, wen=0); IF granted in the cycle o_d_valid pulses.
- IF held high, 6 back-to-back D stores, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D; starve_cnt back to 0 after IF grant.
- Memory stalls i_mem_ready low 5 cycles -> o_mem_req and fields stable all 5 cycles; no second grant.
- D store addr 0x10, wdata 0x12345678, mask 4'b0011 -> o_mem_wen=1, mask 0011 on bus; ack gives o_d_valid with o_d_rdata unchanged.
- i_rst asserted in WAIT, then memory response after release -> no o_*_valid pulse, FSM in IDLE, response ignored.
